// File: rtl/mcdt_arb_pkg.sv
// Shared types and the round-robin search helper for the MCDT output arbiter.
// Latency: n/a (types and a combinational function); backpressure: n/a.
package mcdt_arb_pkg;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef logic [ID_W-1:0] ch_id_t;
    typedef logic [1:0]      prio_t;

    // First set bit of mask searching upward from last+1, wrapping modulo NUM_CH.
    // With an empty mask the result is last; callers qualify it with |mask.
    function automatic ch_id_t rr_next(input ch_id_t last, input logic [NUM_CH-1:0] mask);
        ch_id_t res;
        int     best_off;
        int     off;
        res      = last;
        best_off = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            off = (c + NUM_CH - 1 - int'(last)) % NUM_CH;
            if (mask[c] && (off < best_off)) begin
                best_off = off;
                res      = ch_id_t'(c);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mcdt_rr_pick.sv
// Combinational round-robin pick: rotate mask past last, priority-encode, un-rotate.
// Latency: 0 cycles; backpressure: none, a grant is produced whenever mask is non-zero.
module mcdt_rr_pick
    import mcdt_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  ch_id_t            last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output ch_id_t            id_o,
    output logic              any_o
);

    always_comb begin
        any_o = |mask_i;
        id_o  = rr_next(last_i, mask_i);
        gnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_o[k] = any_o && (id_o == ch_id_t'(k));
        end
    end

endmodule

// File: rtl/mcdt_arbiter.sv
// Shares the MCDT output port between NUM_CH FWFT channel FIFOs (round-robin, or priority with MCDT_ARB_PRIO_EN).
// Latency: 1 cycle req->mcdt_val_o; backpressure: none, one pop and one output word per cycle sustained.
module mcdt_arbiter
    import mcdt_arb_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        en_i,
`ifdef MCDT_ARB_PRIO_EN
    input  logic [NUM_CH*2-1:0]      prio_i,
`endif
    output logic [NUM_CH-1:0]        ack_o,
    output logic [DATA_W-1:0]        mcdt_data_o,
    output logic                     mcdt_val_o,
    output logic [ID_W-1:0]          mcdt_id_o
);

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] pick_mask;
    logic [NUM_CH-1:0] gnt;
    ch_id_t            gnt_id;
    logic              gnt_any;

    ch_id_t            last_q,  last_d;
    logic [DATA_W-1:0] data_q,  data_d;
    ch_id_t            id_q,    id_d;
    logic              val_q,   val_d;

    assign elig = req_i & en_i;

`ifdef MCDT_ARB_PRIO_EN
    prio_t top_prio;

    // Only channels at the highest eligible priority compete; ties fall back to round-robin.
    always_comb begin
        top_prio  = '0;
        pick_mask = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (elig[k] && (prio_i[k*2 +: 2] > top_prio)) begin
                top_prio = prio_i[k*2 +: 2];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            pick_mask[k] = elig[k] && (prio_i[k*2 +: 2] == top_prio);
        end
    end
`else
    assign pick_mask = elig;
`endif

    mcdt_rr_pick u_pick (
        .mask_i (pick_mask),
        .last_i (last_q),
        .gnt_o  (gnt),
        .id_o   (gnt_id),
        .any_o  (gnt_any)
    );

    // Gating with rstn_i keeps FIFOs from popping while the output register is held clear.
    assign ack_o = gnt & {NUM_CH{rstn_i}};

    always_comb begin
        last_d = last_q;
        data_d = data_q;
        id_d   = id_q;
        val_d  = gnt_any;
        if (gnt_any) begin
            last_d = gnt_id;
            id_d   = gnt_id;
            for (int k = 0; k < NUM_CH; k++) begin
                if (gnt[k]) begin
                    data_d = data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= ch_id_t'(NUM_CH - 1);
            data_q <= '0;
            id_q   <= '0;
            val_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            data_q <= data_d;
            id_q   <= id_d;
            val_q  <= val_d;
        end
    end

    assign mcdt_data_o = data_q;
    assign mcdt_id_o   = id_q;
    assign mcdt_val_o  = val_q;

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Directed and random stimulus for mcdt_arbiter, checked against a channel-queue reference model.
module tb_mcdt_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [2:0]  req_i = '0;
    logic [95:0] data_i = '0;
    logic [2:0]  en_i = 3'b111;
    logic [5:0]  prio_v = '0;
    logic [2:0]  ack_o;
    logic [31:0] mcdt_data_o;
    logic        mcdt_val_o;
    logic [1:0]  mcdt_id_o;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_last = 2;
    logic        m_val  = 1'b0;
    logic [31:0] m_data = '0;
    int          m_id   = 0;

    logic [31:0] head [3];
    int          left [3];

    always #5 clk_i = ~clk_i;

    mcdt_arbiter dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .data_i      (data_i),
        .en_i        (en_i),
`ifdef MCDT_ARB_PRIO_EN
        .prio_i      (prio_v),
`endif
        .ack_o       (ack_o),
        .mcdt_data_o (mcdt_data_o),
        .mcdt_val_o  (mcdt_val_o),
        .mcdt_id_o   (mcdt_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Highest priority among eligible channels, ties resolved by distance from last+1.
    function automatic int model_grant(input logic [2:0] el, input int lst, input logic [5:0] pr);
        int top;
        int best;
        int c;
        top  = -1;
        best = -1;
        for (int k = 0; k < 3; k++)
            if (el[k] && int'(pr[k*2 +: 2]) > top) top = int'(pr[k*2 +: 2]);
        for (int i = 1; i <= 3; i++) begin
            c = (lst + i) % 3;
            if (best < 0 && el[c] && int'(pr[c*2 +: 2]) == top) best = c;
        end
        return best;
    endfunction

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle(input string tag, output int g);
        logic [2:0] exp_ack;
        #2;
        if (!rstn_i) begin
            g = -1;
            check({tag, "_rst_val"},  {31'd0, mcdt_val_o}, 32'd0);
            check({tag, "_rst_data"}, mcdt_data_o, 32'd0);
            check({tag, "_rst_id"},   {30'd0, mcdt_id_o}, 32'd0);
            m_last = 2;
            m_val  = 1'b0;
            m_data = '0;
            m_id   = 0;
        end else begin
            g = model_grant(req_i & en_i, m_last, prio_v);
            if (g >= 0) begin
                m_val  = 1'b1;
                m_data = data_i[g*32 +: 32];
                m_id   = g;
                m_last = g;
            end else begin
                m_val = 1'b0;
            end
        end
        exp_ack = (g >= 0) ? 3'(1 << g) : 3'b000;
        check({tag, "_ack"}, {29'd0, ack_o}, {29'd0, exp_ack});
        @(posedge clk_i);
        #1;
        check({tag, "_val"},  {31'd0, mcdt_val_o}, {31'd0, m_val});
        check({tag, "_data"}, mcdt_data_o, m_data);
        check({tag, "_id"},   {30'd0, mcdt_id_o}, 32'(m_id));
    endtask

    task automatic run(input int n, input string tag);
        int g;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) begin
                req_i[k] = (left[k] > 0);
                data_i[k*32 +: 32] = head[k];
            end
            cycle(tag, g);
            if (g >= 0) begin
                head[g] = head[g] + 1;
                left[g] = left[g] - 1;
            end
        end
    endtask

    task automatic reset_pulse(input int n);
        int g;
        rstn_i = 1'b0;
        for (int i = 0; i < n; i++) cycle("rst", g);
        rstn_i = 1'b1;
    endtask

    task automatic load(input logic [31:0] h0, input int l0, input logic [31:0] h1, input int l1,
                        input logic [31:0] h2, input int l2);
        head[0] = h0; left[0] = l0;
        head[1] = h1; left[1] = l1;
        head[2] = h2; left[2] = l2;
    endtask

    initial begin
        int g;
        logic [31:0] exp_d3 [6];
        int          exp_i3 [6];

        @(posedge clk_i);
        #1;

        // 1. reset held with all channels requesting
        rstn_i = 1'b0;
        req_i  = 3'b111;
        data_i = {32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 10; i++) cycle("t1", g);
        rstn_i = 1'b1;

        // 2. single channel, 100 words back-to-back
        load(32'd0, 0, 32'd0, 100, 32'd0, 0);
        for (int i = 0; i < 100; i++) begin
            run(1, "t2");
            check("t2_id_const", {30'd0, mcdt_id_o}, 32'd1);
            check("t2_data_seq", mcdt_data_o, 32'(i));
        end
        run(1, "t2_drain");
        check("t2_drain_val", {31'd0, mcdt_val_o}, 32'd0);

        // 3. all busy after reset: 0,1,2,0,1,2
        reset_pulse(1);
        load(32'hA0, 2, 32'hB0, 2, 32'hC0, 2);
        exp_d3 = '{32'hA0, 32'hB0, 32'hC0, 32'hA1, 32'hB1, 32'hC1};
        exp_i3 = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            run(1, "t3");
            check("t3_id_seq",   {30'd0, mcdt_id_o}, 32'(exp_i3[i]));
            check("t3_data_seq", mcdt_data_o, exp_d3[i]);
        end

        // 4. ch1 masked by en_i
        en_i = 3'b101;
        load(32'h100, 20, 32'h200, 20, 32'h300, 20);
        for (int i = 0; i < 6; i++) begin
            run(1, "t4");
            check("t4_id_alt", {30'd0, mcdt_id_o}, (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        check("t4_ch1_head", head[1], 32'h200);
        en_i = 3'b111;

        // 5. three-cycle gap, then mid-stream reset
        load(32'h10, 0, 32'h20, 0, 32'h30, 0);
        for (int i = 0; i < 3; i++) begin
            run(1, "t5_gap");
            check("t5_gap_val", {31'd0, mcdt_val_o}, 32'd0);
        end
        load(32'h10, 20, 32'h20, 20, 32'h30, 20);
        run(4, "t5_pre");
        reset_pulse(2);
        run(1, "t5_post");
        check("t5_first_id", {30'd0, mcdt_id_o}, 32'd0);
        run(3, "t5_tail");

`ifdef MCDT_ARB_PRIO_EN
        // 6. ch1/ch2 at priority 3 starve ch0 at priority 1
        reset_pulse(1);
        prio_v = {2'd3, 2'd3, 2'd1};
        load(32'h40, 2, 32'h50, 2, 32'h60, 2);
        exp_i3 = '{1, 2, 1, 2, 0, 0};
        for (int i = 0; i < 6; i++) begin
            run(1, "t6");
            check("t6_id_seq", {30'd0, mcdt_id_o}, 32'(exp_i3[i]));
        end
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rstn_i = ($urandom_range(0, 39) != 0);
            req_i  = 3'($urandom);
            en_i   = 3'($urandom | $urandom);
            data_i = {$urandom, $urandom, $urandom};
`ifdef MCDT_ARB_PRIO_EN
            prio_v = 6'($urandom);
`endif
            cycle("rand", g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
